// File: rtl/div_sqrt_mant_sequencer.sv
// Radix-2 non-restoring mantissa divide / square-root sequencer.
// One result bit per cycle, MSB first, followed by a remainder-correction cycle for the sticky bit.
module div_sqrt_mant_sequencer #(
   parameter int unsigned C_DIV_MANT = 23,
   parameter int unsigned C_DIV_ITER = C_DIV_MANT + 2
) (
   input  logic                    Clk_CI,
   input  logic                    Rst_RI,
   input  logic                    Div_start_SI,
   input  logic                    Sqrt_start_SI,
   input  logic                    Kill_SI,
   input  logic                    Exp_odd_SI,
   input  logic [C_DIV_MANT:0]     Operand_a_DI,
   input  logic [C_DIV_MANT:0]     Operand_b_DI,
   output logic                    Ready_SO,
   output logic                    Busy_SO,
   output logic                    Done_SO,
   output logic                    Sqrt_mode_SO,
   output logic [C_DIV_ITER-1:0]   Result_DO,
   output logic                    Sticky_SO
);

   localparam int unsigned W_OP   = C_DIV_MANT + 1;
   localparam int unsigned W_REM  = C_DIV_MANT + 4;
   localparam int unsigned W_RAD  = 2 * C_DIV_ITER;
   localparam int unsigned W_CNT  = $clog2(C_DIV_ITER + 1);
   localparam int unsigned SQ_PAD = W_RAD - (C_DIV_MANT + 2);

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic                  accept_div, accept_sqrt, finish;
   logic                  sqrt_q;
   logic [W_OP-1:0]       opb_q;
   logic [W_REM-1:0]      rem_q;
   logic [W_RAD-1:0]      rad_q;
   logic [C_DIV_ITER-1:0] quo_q;
   logic [W_CNT-1:0]      cnt_q;
   logic [C_DIV_ITER-1:0] result_q;
   logic                  sticky_q;

   logic                  corr_cycle, first_step, rem_neg;
   logic [W_REM-1:0]      shifted, addend, sum;
   logic                  sub, sticky_d;
   logic [C_DIV_MANT+1:0] radicand;

   // ---------------------------------------------------------------- control
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      Ready_SO    = 1'b0;
      Busy_SO     = 1'b0;
      Done_SO     = 1'b0;
      accept_div  = 1'b0;
      accept_sqrt = 1'b0;
      finish      = 1'b0;
      unique case (state_q)
         IDLE: begin
            Ready_SO = 1'b1;
            if (!Kill_SI) begin
               if (Div_start_SI) begin
                  accept_div = 1'b1;
                  state_d    = ITER;
               end else if (Sqrt_start_SI) begin
                  accept_sqrt = 1'b1;
                  state_d     = ITER;
               end
            end
         end
         ITER: begin
            Busy_SO = 1'b1;
            if (Kill_SI) begin
               state_d = IDLE;
            end else if (corr_cycle) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            Done_SO = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------- datapath
   assign corr_cycle = (cnt_q == W_CNT'(C_DIV_ITER));
   assign first_step = (cnt_q == '0);
   assign rem_neg    = rem_q[W_REM-1];
   assign radicand   = Exp_odd_SI ? {Operand_a_DI, 1'b0} : {1'b0, Operand_a_DI};

   // One shared adder: iteration steps use it as add/subtract, the final
   // cycle reuses it to restore a negative remainder for the sticky bit.
   always_comb begin
      shifted = rem_q;
      addend  = W_REM'(opb_q);
      sub     = 1'b0;
      if (corr_cycle) begin
         if (sqrt_q) addend = {1'b0, quo_q, 1'b1};
      end else if (sqrt_q) begin
         shifted = {rem_q[W_REM-3:0], rad_q[W_RAD-1 -: 2]};
         addend  = {quo_q, rem_neg ? 2'b11 : 2'b01};
         sub     = !rem_neg;
      end else begin
         shifted = first_step ? rem_q : {rem_q[W_REM-2:0], 1'b0};
         sub     = !rem_neg;
      end
   end

   assign sum      = shifted + (sub ? ~addend : addend) + W_REM'(sub);
   assign sticky_d = rem_neg ? (sum != '0) : (rem_q != '0);

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         sqrt_q   <= 1'b0;
         opb_q    <= '0;
         rem_q    <= '0;
         rad_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         sticky_q <= 1'b0;
      end else begin
         if (accept_div || accept_sqrt) begin
            sqrt_q <= accept_sqrt;
            opb_q  <= Operand_b_DI;
            rem_q  <= accept_div ? W_REM'(Operand_a_DI) : '0;
            rad_q  <= {radicand, {SQ_PAD{1'b0}}};
            quo_q  <= '0;
            cnt_q  <= '0;
         end else if (Busy_SO) begin
            cnt_q <= cnt_q + W_CNT'(1);
            if (!corr_cycle) begin
               rem_q <= sum;
               quo_q <= {quo_q[C_DIV_ITER-2:0], !sum[W_REM-1]};
               rad_q <= {rad_q[W_RAD-3:0], 2'b00};
            end
         end
         if (finish) begin
            result_q <= quo_q;
            sticky_q <= sticky_d;
         end
      end
   end

   assign Sqrt_mode_SO = sqrt_q;
   assign Result_DO    = result_q;
   assign Sticky_SO    = sticky_q;

endmodule

// File: tb/tb_div_sqrt_mant_sequencer.sv
// Directed and randomized checks for div_sqrt_mant_sequencer at default parameters.
module tb_div_sqrt_mant_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_start = 1'b0;
   logic        sqrt_start = 1'b0;
   logic        kill = 1'b0;
   logic        exp_odd = 1'b0;
   logic [23:0] opa = '0;
   logic [23:0] opb = '0;
   logic        ready, busy, done, sqrt_mode, sticky;
   logic [24:0] result;

   int n_assert = 0;
   int n_fail   = 0;
   int lat, n_done, done_lat;
   logic busy_after_accept, ready_after_accept;

   div_sqrt_mant_sequencer #(.C_DIV_MANT(23)) dut (
      .Clk_CI        (clk),
      .Rst_RI        (rst),
      .Div_start_SI  (div_start),
      .Sqrt_start_SI (sqrt_start),
      .Kill_SI       (kill),
      .Exp_odd_SI    (exp_odd),
      .Operand_a_DI  (opa),
      .Operand_b_DI  (opb),
      .Ready_SO      (ready),
      .Busy_SO       (busy),
      .Done_SO       (done),
      .Sqrt_mode_SO  (sqrt_mode),
      .Result_DO     (result),
      .Sticky_SO     (sticky)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"},  64'(ready),     64'd1);
      check({tag, "_busy"},   64'(busy),      64'd0);
      check({tag, "_done"},   64'(done),      64'd0);
      check({tag, "_mode"},   64'(sqrt_mode), 64'd0);
      check({tag, "_result"}, 64'(result),    64'd0);
      check({tag, "_sticky"}, 64'(sticky),    64'd0);
   endtask

   // Issues one start, then waits (bounded) for Done; lat = cycles after accept edge.
   task automatic run_op(input bit is_sqrt, input logic [23:0] a, input logic [23:0] b,
                         input bit odd, output int latency);
      div_start  = !is_sqrt;
      sqrt_start = is_sqrt;
      opa        = a;
      opb        = b;
      exp_odd    = odd;
      tick();
      div_start  = 1'b0;
      sqrt_start = 1'b0;
      busy_after_accept  = busy;
      ready_after_accept = ready;
      latency = 0;
      while (!done && latency < 200) begin
         tick();
         latency++;
      end
   endtask

   function automatic longint unsigned model_div_q(input logic [23:0] a, input logic [23:0] b);
      longint unsigned num;
      num = {40'b0, a};
      num = num << 24;
      return num / {40'b0, b};
   endfunction

   function automatic bit model_div_s(input logic [23:0] a, input logic [23:0] b);
      longint unsigned num;
      num = {40'b0, a};
      num = num << 24;
      return (num % {40'b0, b}) != 0;
   endfunction

   function automatic longint unsigned isqrt(input longint unsigned x);
      longint unsigned lo, hi, mid;
      lo = 0;
      hi = 64'h400_0000;
      while (lo < hi) begin
         mid = (lo + hi + 1) >> 1;
         if (mid * mid <= x) lo = mid;
         else                hi = mid - 1;
      end
      return lo;
   endfunction

   function automatic longint unsigned model_rad(input logic [23:0] a, input bit odd);
      longint unsigned r;
      r = {40'b0, a};
      if (odd) r = r << 1;
      return r << 25;
   endfunction

   initial begin
      bit          sq, od;
      logic [23:0] ra, rb;
      longint unsigned x, root, exp_q;
      bit          exp_s;

      // reset
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset_values("reset");

      // div 1.0 / 1.0
      run_op(1'b0, 24'h800000, 24'h800000, 1'b0, lat);
      check("div_one_busy",    64'(busy_after_accept),  64'd1);
      check("div_one_ready",   64'(ready_after_accept), 64'd0);
      check("div_one_latency", 64'(lat),    64'd26);
      check("div_one_result",  64'(result), 64'h1000000);
      check("div_one_sticky",  64'(sticky), 64'd0);
      check("div_one_mode",    64'(sqrt_mode), 64'd0);
      tick();
      check("after_done_ready", 64'(ready), 64'd1);
      check("after_done_done",  64'(done),  64'd0);

      // div 1.0 / 1.5
      run_op(1'b0, 24'h800000, 24'hC00000, 1'b0, lat);
      check("div_two_thirds_latency", 64'(lat),    64'd26);
      check("div_two_thirds_result",  64'(result), 64'hAAAAAA);
      check("div_two_thirds_sticky",  64'(sticky), 64'd1);
      tick();

      // sqrt 1.0, even exponent
      run_op(1'b1, 24'h800000, 24'h000000, 1'b0, lat);
      check("sqrt_one_latency", 64'(lat),    64'd26);
      check("sqrt_one_result",  64'(result), 64'h1000000);
      check("sqrt_one_sticky",  64'(sticky), 64'd0);
      check("sqrt_one_mode",    64'(sqrt_mode), 64'd1);
      tick();

      // sqrt 2.0 (odd exponent)
      run_op(1'b1, 24'h800000, 24'h000000, 1'b1, lat);
      check("sqrt_two_result", 64'(result), 64'h16A09E6);
      check("sqrt_two_sticky", 64'(sticky), 64'd1);
      check("sqrt_two_mode",   64'(sqrt_mode), 64'd1);
      tick();

      // boundary quotients and root
      run_op(1'b0, 24'hFFFFFF, 24'h800000, 1'b0, lat);
      check("div_max_result", 64'(result), 64'h1FFFFFE);
      check("div_max_sticky", 64'(sticky), 64'd0);
      tick();
      run_op(1'b0, 24'h800000, 24'hFFFFFF, 1'b0, lat);
      check("div_min_result", 64'(result), 64'h800000);
      check("div_min_sticky", 64'(sticky), 64'd1);
      tick();
      run_op(1'b1, 24'hFFFFFF, 24'h000000, 1'b1, lat);
      check("sqrt_max_result", 64'(result), 64'h1FFFFFE);
      check("sqrt_max_sticky", 64'(sticky), 64'd1);
      tick();

      // both starts together: division wins (sqrt of 1.5 would differ)
      div_start  = 1'b1;
      sqrt_start = 1'b1;
      opa        = 24'hC00000;
      opb        = 24'h800000;
      exp_odd    = 1'b0;
      tick();
      div_start  = 1'b0;
      sqrt_start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         tick();
         lat++;
      end
      check("both_start_latency", 64'(lat),       64'd26);
      check("both_start_mode",    64'(sqrt_mode), 64'd0);
      check("both_start_result",  64'(result),    64'h1800000);
      check("both_start_sticky",  64'(sticky),    64'd0);
      tick();

      // starts while busy are ignored
      div_start = 1'b1;
      opa       = 24'h800000;
      opb       = 24'hC00000;
      tick();
      div_start = 1'b0;
      lat      = 0;
      n_done   = 0;
      done_lat = -1;
      repeat (70) begin
         sqrt_start = (lat == 3);
         div_start  = (lat == 25);
         if (lat == 25) begin
            opa = 24'hFFFFFF;
            opb = 24'h800000;
         end
         tick();
         lat++;
         if (done) begin
            n_done++;
            if (done_lat < 0) done_lat = lat;
         end
      end
      sqrt_start = 1'b0;
      div_start  = 1'b0;
      check("busy_start_done_count", 64'(n_done),    64'd1);
      check("busy_start_done_lat",   64'(done_lat),  64'd26);
      check("busy_start_result",     64'(result),    64'hAAAAAA);
      check("busy_start_sticky",     64'(sticky),    64'd1);
      check("busy_start_mode",       64'(sqrt_mode), 64'd0);

      // kill together with start in IDLE
      kill      = 1'b1;
      div_start = 1'b1;
      opa       = 24'hFFFFFF;
      opb       = 24'h800000;
      tick();
      kill      = 1'b0;
      div_start = 1'b0;
      check("kill_idle_ready", 64'(ready), 64'd1);
      check("kill_idle_busy",  64'(busy),  64'd0);
      n_done = 0;
      repeat (30) begin
         tick();
         if (done) n_done++;
      end
      check("kill_idle_no_done", 64'(n_done), 64'd0);
      check("kill_idle_result",  64'(result), 64'hAAAAAA);

      // kill at iteration 10
      div_start = 1'b1;
      opa       = 24'hFFFFFF;
      opb       = 24'h800000;
      tick();
      div_start = 1'b0;
      repeat (10) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill_iter_ready",  64'(ready),  64'd1);
      check("kill_iter_busy",   64'(busy),   64'd0);
      check("kill_iter_done",   64'(done),   64'd0);
      check("kill_iter_result", 64'(result), 64'hAAAAAA);
      check("kill_iter_sticky", 64'(sticky), 64'd1);
      n_done = 0;
      repeat (40) begin
         tick();
         if (done) n_done++;
      end
      check("kill_iter_no_done", 64'(n_done), 64'd0);

      // reset at iteration 10
      sqrt_start = 1'b1;
      opa        = 24'h800000;
      exp_odd    = 1'b1;
      tick();
      sqrt_start = 1'b0;
      exp_odd    = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check_reset_values("reset_mid");
      rst = 1'b0;
      tick();

      // randomized normalized operands against the exact formulas
      for (int i = 0; i < 1000; i++) begin
         sq = 1'($urandom_range(0, 1));
         od = 1'($urandom_range(0, 1));
         ra = {1'b1, 23'($urandom)};
         rb = {1'b1, 23'($urandom)};
         run_op(sq, ra, rb, od, lat);
         if (sq) begin
            x     = model_rad(ra, od);
            root  = isqrt(x);
            exp_q = root;
            exp_s = (root * root) != x;
         end else begin
            exp_q = model_div_q(ra, rb);
            exp_s = model_div_s(ra, rb);
         end
         check("rand_latency", 64'(lat),    64'd26);
         check("rand_result",  64'(result), exp_q);
         check("rand_sticky",  64'(sticky), 64'(exp_s));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
